// File: rtl/calc_dispatcher.sv
// Command sequencer for Calculator_Core: validates one matrix command, issues it with a single
// start pulse, and watches for completion. Every command ends in one success or error response.
module calc_dispatcher #(
   parameter int unsigned TIMEOUT_CYCLES  = 4096,
   parameter int unsigned ERR_HOLD_CYCLES = 100_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [2:0]  i_cmd_op,
   input  logic [7:0]  i_a_addr,
   input  logic [31:0] i_a_m,
   input  logic [31:0] i_a_n,
   input  logic [7:0]  i_b_addr,
   input  logic [31:0] i_b_m,
   input  logic [31:0] i_b_n,
   input  logic [7:0]  i_res_addr,
   output logic        o_start_calc,
   output logic [2:0]  o_op_code,
   output logic [7:0]  o_op1_addr,
   output logic [31:0] o_op1_m,
   output logic [31:0] o_op1_n,
   output logic [7:0]  o_op2_addr,
   output logic [31:0] o_op2_m,
   output logic [31:0] o_op2_n,
   output logic [7:0]  o_res_addr,
   input  logic        i_calc_done,
   output logic        o_busy,
   output logic        o_rsp_valid,
   output logic        o_rsp_err,
   output logic [2:0]  o_err_code,
   output logic [31:0] o_res_m,
   output logic [31:0] o_res_n,
   output logic        o_err_active
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StCheck   = 3'd1;
   localparam logic [2:0] StStart   = 3'd2;
   localparam logic [2:0] StWait    = 3'd3;
   localparam logic [2:0] StResp    = 3'd4;
   localparam logic [2:0] StErrHold = 3'd5;

   localparam logic [32:0] TimeoutLim = 33'(TIMEOUT_CYCLES);
   localparam logic [32:0] HoldLim    = 33'(ERR_HOLD_CYCLES);

   localparam logic [2:0] ErrNone     = 3'd0;
   localparam logic [2:0] ErrRange    = 3'd1;
   localparam logic [2:0] ErrMismatch = 3'd2;
   localparam logic [2:0] ErrOpcode   = 3'd3;
   localparam logic [2:0] ErrTimeout  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  op_code_q, op_code_d;
   logic [7:0]  op1_addr_q, op1_addr_d, op2_addr_q, op2_addr_d, res_addr_q, res_addr_d;
   logic [31:0] op1_m_q, op1_m_d, op1_n_q, op1_n_d;
   logic [31:0] op2_m_q, op2_m_d, op2_n_q, op2_n_d;
   logic [31:0] res_m_q, res_m_d, res_n_q, res_n_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [2:0]  err_code_q, err_code_d;

   logic [2:0]  chk_code;
   logic [31:0] chk_m, chk_n;
   logic [32:0] cnt_inc;
   logic [31:0] cnt_sat;

   function automatic logic in_range(input logic [31:0] v);
      return (v >= 32'd1) && (v <= 32'd5);
   endfunction

   // Rules in priority order; the first failing one wins.
   always_comb begin
      chk_code = ErrNone;
      if (op_code_q > 3'd3) begin
         chk_code = ErrOpcode;
      end else if (!in_range(op1_m_q) || !in_range(op1_n_q)) begin
         chk_code = ErrRange;
      end else if ((op_code_q == 3'd1 || op_code_q == 3'd3) &&
                   (!in_range(op2_m_q) || !in_range(op2_n_q))) begin
         chk_code = ErrRange;
      end else if (op_code_q == 3'd1 && (op2_m_q != op1_m_q || op2_n_q != op1_n_q)) begin
         chk_code = ErrMismatch;
      end else if (op_code_q == 3'd3 && op1_n_q != op2_m_q) begin
         chk_code = ErrMismatch;
      end
   end

   always_comb begin
      chk_m = op1_m_q;
      chk_n = op1_n_q;
      case (op_code_q)
         3'd0:    begin chk_m = op1_n_q; chk_n = op1_m_q; end
         3'd3:    begin chk_m = op1_m_q; chk_n = op2_n_q; end
         default: begin chk_m = op1_m_q; chk_n = op1_n_q; end
      endcase
   end

   assign cnt_inc = {1'b0, cnt_q} + 33'd1;
   assign cnt_sat = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_code_d   = op_code_q;
      op1_addr_d  = op1_addr_q;
      op1_m_d     = op1_m_q;
      op1_n_d     = op1_n_q;
      op2_addr_d  = op2_addr_q;
      op2_m_d     = op2_m_q;
      op2_n_d     = op2_n_q;
      res_addr_d  = res_addr_q;
      res_m_d     = res_m_q;
      res_n_d     = res_n_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      err_code_d  = err_code_q;
      case (state_q)
         StIdle: begin
            err_code_d = ErrNone;
            if (i_cmd_valid) begin
               op_code_d  = i_cmd_op;
               op1_addr_d = i_a_addr;
               op1_m_d    = i_a_m;
               op1_n_d    = i_a_n;
               op2_addr_d = i_b_addr;
               op2_m_d    = i_b_m;
               op2_n_d    = i_b_n;
               res_addr_d = i_res_addr;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            res_m_d = chk_m;
            res_n_d = chk_n;
            if (chk_code != ErrNone) begin
               state_d     = StErrHold;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               err_code_d  = chk_code;
            end else begin
               state_d = StStart;
            end
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // Done in the same cycle as expiry still counts as success.
            if (i_calc_done) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               err_code_d  = ErrNone;
            end else if (cnt_inc >= TimeoutLim) begin
               state_d     = StErrHold;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               err_code_d  = ErrTimeout;
            end else begin
               cnt_d = cnt_sat;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         StErrHold: begin
            if (cnt_inc >= HoldLim) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_sat;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         op_code_q   <= '0;
         op1_addr_q  <= '0;
         op1_m_q     <= '0;
         op1_n_q     <= '0;
         op2_addr_q  <= '0;
         op2_m_q     <= '0;
         op2_n_q     <= '0;
         res_addr_q  <= '0;
         res_m_q     <= '0;
         res_n_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_code_q   <= op_code_d;
         op1_addr_q  <= op1_addr_d;
         op1_m_q     <= op1_m_d;
         op1_n_q     <= op1_n_d;
         op2_addr_q  <= op2_addr_d;
         op2_m_q     <= op2_m_d;
         op2_n_q     <= op2_n_d;
         res_addr_q  <= res_addr_d;
         res_m_q     <= res_m_d;
         res_n_q     <= res_n_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign o_cmd_ready  = (state_q == StIdle);
   assign o_busy       = (state_q != StIdle);
   assign o_start_calc = (state_q == StStart);
   assign o_err_active = (state_q == StErrHold);
   assign o_op_code    = op_code_q;
   assign o_op1_addr   = op1_addr_q;
   assign o_op1_m      = op1_m_q;
   assign o_op1_n      = op1_n_q;
   assign o_op2_addr   = op2_addr_q;
   assign o_op2_m      = op2_m_q;
   assign o_op2_n      = op2_n_q;
   assign o_res_addr   = res_addr_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_err    = rsp_err_q;
   assign o_err_code   = err_code_q;
   assign o_res_m      = res_m_q;
   assign o_res_n      = res_n_q;

endmodule

// File: tb/tb_calc_dispatcher.sv
// Scoreboard bench for calc_dispatcher: expected responses are queued as commands are driven
// and compared by a monitor whenever the DUT emits a response.
module tb_calc_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [2:0]  i_cmd_op;
   logic [7:0]  i_a_addr, i_b_addr, i_res_addr;
   logic [31:0] i_a_m, i_a_n, i_b_m, i_b_n;
   logic        o_start_calc;
   logic [2:0]  o_op_code;
   logic [7:0]  o_op1_addr, o_op2_addr, o_res_addr;
   logic [31:0] o_op1_m, o_op1_n, o_op2_m, o_op2_n;
   logic        i_calc_done;
   logic        o_busy, o_rsp_valid, o_rsp_err, o_err_active;
   logic [2:0]  o_err_code;
   logic [31:0] o_res_m, o_res_n;

   calc_dispatcher #(
      .TIMEOUT_CYCLES (16),
      .ERR_HOLD_CYCLES(8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_op    (i_cmd_op),
      .i_a_addr    (i_a_addr),
      .i_a_m       (i_a_m),
      .i_a_n       (i_a_n),
      .i_b_addr    (i_b_addr),
      .i_b_m       (i_b_m),
      .i_b_n       (i_b_n),
      .i_res_addr  (i_res_addr),
      .o_start_calc(o_start_calc),
      .o_op_code   (o_op_code),
      .o_op1_addr  (o_op1_addr),
      .o_op1_m     (o_op1_m),
      .o_op1_n     (o_op1_n),
      .o_op2_addr  (o_op2_addr),
      .o_op2_m     (o_op2_m),
      .o_op2_n     (o_op2_n),
      .o_res_addr  (o_res_addr),
      .i_calc_done (i_calc_done),
      .o_busy      (o_busy),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_err   (o_rsp_err),
      .o_err_code  (o_err_code),
      .o_res_m     (o_res_m),
      .o_res_n     (o_res_n),
      .o_err_active(o_err_active)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [2:0]  code;
      logic [31:0] m;
      logic [31:0] n;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = -1, start_cyc = -1, rsp_cyc = -1;
   int   n_start = 0, n_rsp = 0, n_erract = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_cmd_ready && i_cmd_valid) acc_cyc = cyc;
         if (o_start_calc) begin
            start_cyc = cyc;
            n_start++;
         end
         if (o_err_active) n_erract++;
         if (o_rsp_valid) begin
            exp_t e;
            rsp_cyc = cyc;
            n_rsp++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
               check_eq("rsp_code", {29'd0, o_err_code}, {29'd0, e.code});
               if (!e.err) begin
                  check_eq("rsp_res_m", o_res_m, e.m);
                  check_eq("rsp_res_n", o_res_n, e.n);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [2:0] op, input logic [31:0] am, input logic [31:0] an,
                            input logic [31:0] bm, input logic [31:0] bn);
      i_cmd_op   = op;
      i_a_addr   = 8'h10 + 8'(op);
      i_a_m      = am;
      i_a_n      = an;
      i_b_addr   = 8'h40 + 8'(op);
      i_b_m      = bm;
      i_b_n      = bn;
      i_res_addr = 8'h80 + 8'(op);
      i_cmd_valid = 1'b1;
   endtask

   // Drive a command, queue its expectation, and return in the cycle after acceptance.
   task automatic send(input logic [2:0] op, input logic [31:0] am, input logic [31:0] an,
                       input logic [31:0] bm, input logic [31:0] bn, input logic push,
                       input logic e_err, input logic [2:0] e_code,
                       input logic [31:0] e_m, input logic [31:0] e_n);
      int k;
      if (push) exp_q.push_back('{err: e_err, code: e_code, m: e_m, n: e_n});
      drive_cmd(op, am, an, bm, bn);
      k = 0;
      while (k < 200) begin
         @(negedge clk);
         if (o_cmd_ready) break;
         k++;
      end
      if (k == 200) check_eq("accept_bound", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic pulse_done(output int d);
      d = cyc;
      i_calc_done = 1'b1;
      tick(1);
      i_calc_done = 1'b0;
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!o_cmd_ready && k < 100) begin
         tick(1);
         k++;
      end
      if (k == 100) check_eq("ready_bound", 32'd0, 32'd1);
   endtask

   initial begin
      int d, s0, r0, e0, k;
      rst_n = 1'b0;
      i_cmd_valid = 1'b0;
      i_calc_done = 1'b0;
      drive_cmd(3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      i_cmd_valid = 1'b0;
      tick(3);
      check_eq("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
      check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
      check_eq("rst_start", {31'd0, o_start_calc}, 32'd0);
      check_eq("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      check_eq("rst_op1_m", o_op1_m, 32'd0);
      check_eq("rst_err_active", {31'd0, o_err_active}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Legal transpose 2x3 -> 3x2
      s0 = n_start;
      send(3'd0, 32'd2, 32'd3, 32'd7, 32'd9, 1'b1, 1'b0, 3'd0, 32'd3, 32'd2);
      tick(4);
      check_eq("t0_start_cycle", start_cyc, acc_cyc + 2);
      check_eq("t0_start_count", n_start - s0, 32'd1);
      check_eq("t0_op_code", {29'd0, o_op_code}, 32'd0);
      check_eq("t0_op1_m", o_op1_m, 32'd2);
      check_eq("t0_op1_n", o_op1_n, 32'd3);
      check_eq("t0_op2_n", o_op2_n, 32'd9);
      check_eq("t0_op1_addr", {24'd0, o_op1_addr}, 32'h10);
      check_eq("t0_res_addr", {24'd0, o_res_addr}, 32'h80);
      check_eq("t0_busy", {31'd0, o_busy}, 32'd1);
      check_eq("t0_ready_wait", {31'd0, o_cmd_ready}, 32'd0);
      pulse_done(d);
      check_eq("t0_ready_resp", {31'd0, o_cmd_ready}, 32'd0);
      tick(1);
      check_eq("t0_rsp_cycle", rsp_cyc, d + 1);
      check_eq("t0_ready_back", {31'd0, o_cmd_ready}, 32'd1);
      tick(1);

      // Multiply mismatch: 2x3 * 2x2
      s0 = n_start;
      e0 = n_erract;
      send(3'd3, 32'd2, 32'd3, 32'd2, 32'd2, 1'b1, 1'b1, 3'd2, 32'd0, 32'd0);
      tick(1);
      check_eq("mm_err_active", {31'd0, o_err_active}, 32'd1);
      tick(7);
      check_eq("mm_ready_early", {31'd0, o_cmd_ready}, 32'd0);
      tick(1);
      check_eq("mm_ready_back", {31'd0, o_cmd_ready}, 32'd1);
      check_eq("mm_err_active_off", {31'd0, o_err_active}, 32'd0);
      check_eq("mm_rsp_cycle", rsp_cyc, acc_cyc + 2);
      check_eq("mm_hold_len", n_erract - e0, 32'd8);
      check_eq("mm_no_start", n_start - s0, 32'd0);

      // Range and opcode errors; each send waits out the previous hold.
      s0 = n_start;
      send(3'd1, 32'd6, 32'd2, 32'd6, 32'd2, 1'b1, 1'b1, 3'd1, 32'd0, 32'd0);
      send(3'd5, 32'd9, 32'd0, 32'd9, 32'd9, 1'b1, 1'b1, 3'd3, 32'd0, 32'd0);
      send(3'd1, 32'd2, 32'd2, 32'd2, 32'd3, 1'b1, 1'b1, 3'd2, 32'd0, 32'd0);
      send(3'd3, 32'd2, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, 3'd1, 32'd0, 32'd0);
      wait_ready();
      check_eq("err_no_start", n_start - s0, 32'd0);

      // Watchdog: scalar multiply, done never comes
      r0 = n_rsp;
      send(3'd2, 32'd3, 32'd4, 32'd100, 32'd77, 1'b1, 1'b1, 3'd4, 32'd0, 32'd0);
      k = 0;
      while (n_rsp == r0 && k < 60) begin
         tick(1);
         k++;
      end
      check_eq("wd_rsp_seen", n_rsp - r0, 32'd1);
      check_eq("wd_latency", rsp_cyc - start_cyc, 32'd17);
      wait_ready();

      // Done in the last WAIT cycle beats the watchdog; scalar 100 is not range-checked
      send(3'd2, 32'd3, 32'd4, 32'd100, 32'd0, 1'b1, 1'b0, 3'd0, 32'd3, 32'd4);
      tick(17);
      pulse_done(d);
      tick(1);
      check_eq("late_done_rsp_cycle", rsp_cyc, d + 1);
      wait_ready();

      // Stray done in IDLE
      r0 = n_rsp;
      pulse_done(d);
      tick(3);
      check_eq("stray_done_rsp", n_rsp - r0, 32'd0);
      check_eq("stray_done_busy", {31'd0, o_busy}, 32'd0);

      // Second request held during WAIT is taken the cycle ready rises
      send(3'd1, 32'd2, 32'd2, 32'd2, 32'd2, 1'b1, 1'b0, 3'd0, 32'd2, 32'd2);
      tick(3);
      exp_q.push_back('{err: 1'b0, code: 3'd0, m: 32'd1, n: 32'd1});
      drive_cmd(3'd3, 32'd1, 32'd5, 32'd5, 32'd1);
      tick(3);
      check_eq("busy_req_op_code", {29'd0, o_op_code}, 32'd1);
      check_eq("busy_req_op1_n", o_op1_n, 32'd2);
      check_eq("busy_req_ready", {31'd0, o_cmd_ready}, 32'd0);
      pulse_done(d);
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (o_cmd_ready) break;
         k++;
      end
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
      check_eq("busy_req_accept_cycle", acc_cyc, d + 2);
      check_eq("busy_req_new_op", {29'd0, o_op_code}, 32'd3);
      tick(3);
      pulse_done(d);
      tick(1);
      wait_ready();

      // Reset during WAIT: no response, everything cleared
      r0 = n_rsp;
      send(3'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      tick(3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check_eq("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      check_eq("mid_rst_start", {31'd0, o_start_calc}, 32'd0);
      check_eq("mid_rst_op1_m", o_op1_m, 32'd0);
      check_eq("mid_rst_res_m", o_res_m, 32'd0);
      check_eq("mid_rst_ready", {31'd0, o_cmd_ready}, 32'd1);
      tick(2);
      check_eq("mid_rst_no_rsp", n_rsp - r0, 32'd0);
      send(3'd3, 32'd2, 32'd3, 32'd3, 32'd4, 1'b1, 1'b0, 3'd0, 32'd2, 32'd4);
      tick(3);
      pulse_done(d);
      tick(2);

      check_eq("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/calc_dispatcher.md
# calc_dispatcher

Command sequencer in front of `Calculator_Core`. It accepts one matrix-operation command from the top-level FSM and checks the operand dimensions and opcode. A legal command is issued to the core as a single start pulse with frozen parameters, and the block then waits for completion under a watchdog. Every command ends with exactly one response, success or error; errors are followed by a timed error-hold window for the display path.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum cycles in WAIT before a timeout error.
- `ERR_HOLD_CYCLES`, default 100_000_000: length of the `o_err_active` window (1 s at 100 MHz).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: high only in IDLE. A command is accepted when valid && ready.
- `i_cmd_op` in 3: opcode. 0 = transpose, 1 = add, 2 = scalar multiply, 3 = matrix multiply.
- `i_a_addr` in 8, `i_a_m` in 32, `i_a_n` in 32: operand A base address, rows, columns.
- `i_b_addr` in 8, `i_b_m` in 32, `i_b_n` in 32: operand B. For op 2, `i_b_m` carries the scalar.
- `i_res_addr` in 8: result base address.
- `o_start_calc` out 1: start pulse to the core.
- `o_op_code` out 3, `o_op1_addr` out 8, `o_op1_m` out 32, `o_op1_n` out 32: core parameters.
- `o_op2_addr` out 8, `o_op2_m` out 32, `o_op2_n` out 32, `o_res_addr` out 8: core parameters.
- `i_calc_done` in 1: completion pulse from the core.
- `o_busy` out 1: high in every state except IDLE.
- `o_rsp_valid` out 1: response pulse, exactly one per accepted command.
- `o_rsp_err` out 1: response is an error.
- `o_err_code` out 3: 0 = none, 1 = dimension out of range, 2 = dimension mismatch, 3 = illegal opcode, 4 = timeout.
- `o_res_m` out 32, `o_res_n` out 32: result dimensions. Valid with `o_rsp_valid` when `o_rsp_err` = 0.
- `o_err_active` out 1: high during ERR_HOLD.

## Operation
- States: IDLE, CHECK, START, WAIT, RESP, ERR_HOLD.
- **IDLE.** `o_cmd_ready` = 1. On accept, register all command fields into the core-parameter outputs, then go to CHECK. The outputs stay frozen until the block re-enters IDLE.
- **CHECK** (one cycle). Rules are evaluated in priority order; the first failing rule sets the error code.
  - Opcode greater than 3 → code 3.
  - `a_m` or `a_n` outside 1..5 → code 1.
  - Op 1 or op 3 with `b_m` or `b_n` outside 1..5 → code 1.
  - Op 1 with (`b_m`, `b_n`) ≠ (`a_m`, `a_n`) → code 2.
  - Op 3 with `a_n` ≠ `b_m` → code 2.
  - Op 0 and op 2 ignore `b_n`. Op 2 does not range-check the scalar.
  - Legal → START. Illegal → ERR_HOLD, with `o_rsp_valid` = 1, `o_rsp_err` = 1 and the code on the entry cycle.
- **Result dimensions**, computed in CHECK:
  - op 0: (`a_n`, `a_m`).
  - ops 1 and 2: (`a_m`, `a_n`).
  - op 3: (`a_m`, `b_n`).
- **START.** `o_start_calc` = 1 for this one cycle only, then WAIT. The watchdog counter clears.
- **WAIT.**
  - `i_calc_done` = 1 → RESP.
  - Counter reaches `TIMEOUT_CYCLES` → ERR_HOLD with code 4.
- **RESP.** `o_rsp_valid` = 1, `o_rsp_err` = 0, code 0, result dimensions driven. Next state IDLE.
- **ERR_HOLD.** `o_err_active` = 1 for exactly `ERR_HOLD_CYCLES` cycles, then IDLE. No command is accepted during the hold.
- **Ignored inputs.**
  - `i_calc_done` outside WAIT is ignored.
  - `i_cmd_valid` outside IDLE is ignored; the requester holds it until accepted.

## Timing
- **Reset values.** Every output is 0 and the state is IDLE. The one exception is `o_cmd_ready`, which is 1 from the first cycle after reset.
- **Reset mid-operation.** The next edge returns the block to IDLE with no response. The core shares `rst_n` and is reset in the same cycle.
- **Cycle sequence, legal command:**
  - Accept at edge T.
  - CHECK in cycle T+1.
  - `o_start_calc` high in cycle T+2.
  - WAIT from T+3.
  - If done is sampled at edge D, `o_rsp_valid` is high in cycle D+1 and `o_cmd_ready` returns in cycle D+2.
- **Cycle sequence, illegal command:** `o_rsp_valid` is high in cycle T+2 (the ERR_HOLD entry cycle). `o_cmd_ready` returns `ERR_HOLD_CYCLES` cycles after T+2.
- **Timeout:** the error response appears `TIMEOUT_CYCLES` + 1 cycles after the start pulse, the cycle after the counter expires.
- **Simultaneous events:** done arriving in the same cycle the counter expires counts as success; done wins.
- **Counter widths:** 32-bit, saturating; no wrap.

## Test plan
- **Legal transpose.** Op 0, A = 2×3 → one `o_start_calc` pulse in cycle T+2. Parameter outputs stay stable through WAIT. After done: `o_rsp_valid` with err = 0, `o_res_m` = 3, `o_res_n` = 2.
- **Multiply mismatch.** Op 3, A = 2×3, B = 2×2 → no start pulse. Response err = 1, code 2. `o_err_active` high for `ERR_HOLD_CYCLES` = 8 cycles, then `o_cmd_ready` = 1.
- **Range and opcode errors.** Op 1, A = 6×2 → code 1. Op 5 with any dimensions → code 3, taking priority over range.
- **Watchdog.** Op 2 with `TIMEOUT_CYCLES` = 16 and done never asserted → response code 4 exactly 17 cycles after the start pulse.
- **Stray done and busy requests.** `i_calc_done` pulsed in IDLE → no response. A second `i_cmd_valid` during WAIT → not accepted and no parameter change; it is accepted in the cycle `o_cmd_ready` rises.
- **Reset mid-WAIT.** `rst_n` = 0 for one cycle during WAIT → all outputs 0, no `o_rsp_valid`. A following legal op 3 with A = 2×3, B = 3×4 completes with result 2×4.
